// File: rtl/signed_sat_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : signed_sat_accumulator
// Purpose  : Accumulates frames of N signed W-bit samples with per-step
//            saturation. It presents each frame total on a valid/ready output
//            and stalls input while the result waits for the consumer.
// Ports    : clk        - single clock, rising-edge active
//            rst_n      - asynchronous active-low reset
//            in_valid   - in_data is valid this cycle
//            in_ready   - block can accept a sample (high while accumulating)
//            in_data    - signed W-bit sample
//            out_valid  - frame result available (high while holding)
//            out_ready  - consumer takes the result this cycle
//            out_sum    - signed saturated frame sum (0 while accumulating)
//            out_sat    - a saturation event occurred in the frame
// Revision : 1.0 - initial release
// ============================================================================
module signed_sat_accumulator #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_sat
);

  // Counter spans 0..N-1; N >= 2 keeps this at least one bit wide.
  localparam int unsigned  CNT_W    = (N > 2) ? $clog2(N) : 1;
  localparam [CNT_W-1:0]   CNT_LAST = CNT_W'(N - 1);
  localparam [W-1:0]       SAT_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam [W-1:0]       SAT_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_flag_q, sat_flag_d;

  // Saturating step. Overflow is detected from the operand and result sign
  // bits, so no wider adder is needed.
  logic [W-1:0] raw_sum;
  logic         pos_ovf;
  logic         neg_ovf;
  logic [W-1:0] step_sum;
  logic         step_sat;

  always_comb begin
    raw_sum  = acc_q + in_data;
    pos_ovf  = ~acc_q[W-1] & ~in_data[W-1] &  raw_sum[W-1];
    neg_ovf  =  acc_q[W-1] &  in_data[W-1] & ~raw_sum[W-1];
    step_sat = pos_ovf | neg_ovf;
    if (pos_ovf) begin
      step_sum = SAT_MAX;
    end else if (neg_ovf) begin
      step_sum = SAT_MIN;
    end else begin
      step_sum = raw_sum;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_flag_d = sat_flag_q;
    unique case (state_q)
      ACCUM: begin
        // in_ready is high in ACCUM, so in_valid alone marks an accept.
        if (in_valid) begin
          acc_d      = step_sum;
          sat_flag_d = sat_flag_q | step_sat;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // Result consumed: start the next frame from a clean slate.
        if (out_ready) begin
          state_d    = ACCUM;
          acc_d      = '0;
          cnt_d      = '0;
          sat_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Outputs depend on state only, so they are glitch-free with respect to
  // the input handshakes and remain stable across an output stall.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_sum   = (state_q == HOLD) ? acc_q : '0;
    out_sat   = (state_q == HOLD) ? sat_flag_q : 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_sat_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_sat_accumulator
// Purpose  : Scoreboard bench for signed_sat_accumulator. A reference model
//            computes clamped frame totals with integer arithmetic, and a
//            monitor compares each presented result against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_signed_sat_accumulator;

  localparam int W    = 4;
  localparam int N    = 4;
  localparam int VMAX = (1 << (W - 1)) - 1;
  localparam int VMIN = -(1 << (W - 1));

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_sat;

  signed_sat_accumulator #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int sat;
  } result_t;

  result_t sb[$];
  int      errors   = 0;
  int      checks   = 0;
  int      pops     = 0;
  int      last_sum = 0;
  int      last_sat = 0;
  int      m_accepts = 0;
  bit      rand_rdy  = 1'b0;

  // Reference model state: running clamped sum of the current frame.
  int m_sum  = 0;
  int m_cnt  = 0;
  int m_sat  = 0;
  bit m_hold = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame total is the clamped running sum of N accepted
  // samples; inputs are ignored while a result waits for the consumer.
  always @(posedge clk or negedge rst_n) begin
    int t;
    if (!rst_n) begin
      m_sum  = 0;
      m_cnt  = 0;
      m_sat  = 0;
      m_hold = 1'b0;
      sb.delete();
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      m_accepts++;
      t = m_sum + int'($signed(in_data));
      if (t > VMAX) begin
        t = VMAX;
        m_sat = 1;
      end else if (t < VMIN) begin
        t = VMIN;
        m_sat = 1;
      end
      m_sum = t;
      m_cnt++;
      if (m_cnt == N) begin
        sb.push_back('{sum: m_sum, sat: m_sat});
        m_hold = 1'b1;
        m_sum  = 0;
        m_cnt  = 0;
        m_sat  = 0;
      end
    end
  end

  // Monitor: checks the output side every cycle, pops on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("out_valid", int'(out_valid), (sb.size() > 0) ? 1 : 0);
        chk("in_ready", int'(in_ready), (sb.size() > 0) ? 0 : 1);
        if (sb.size() > 0) begin
          chk("out_sum", int'($signed(out_sum)), sb[0].sum);
          chk("out_sat", int'(out_sat), sb[0].sat);
          if (out_valid && out_ready) begin
            last_sum = int'($signed(out_sum));
            last_sat = int'(out_sat);
            void'(sb.pop_front());
            pops++;
          end
        end else begin
          chk("idle_out_sum", int'($signed(out_sum)), 0);
          chk("idle_out_sat", int'(out_sat), 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic put(input int x, input int gap);
    int a0;
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    a0       = m_accepts;
    in_valid = 1'b1;
    in_data  = W'(x);
    n        = 0;
    do begin
      tick();
      n++;
    end while (m_accepts == a0 && n < 64);
    in_valid = 1'b0;
    if (m_accepts == a0) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: sample %0d not accepted in %0d cycles", x, n);
    end
  endtask

  task automatic wait_pop(input int p0, input string name);
    int n;
    n = 0;
    while (pops == p0 && n < 64) begin
      tick();
      n++;
    end
    chk(name, (pops != p0) ? 1 : 0, 1);
  endtask

  task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                           input int gap, input int esum, input int esat);
    int p0;
    p0 = pops;
    put(s0, gap);
    put(s1, gap);
    put(s2, gap);
    put(s3, gap);
    wait_pop(p0, "frame_delivered");
    chk("frame_sum_const", last_sum, esum);
    chk("frame_sat_const", last_sat, esat);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain frame, positive clamp, negative clamp.
    run_frame(1, 2, 3, -1, 0, 5, 0);
    run_frame(7, 1, -2, 0, 0, 5, 1);
    run_frame(-8, -1, 3, 0, 0, -5, 1);

    // Output stall with input pressure: nothing may be absorbed.
    out_ready = 1'b0;
    p0 = pops;
    put(1, 0);
    put(1, 0);
    put(1, 0);
    put(1, 0);
    in_valid = 1'b1;
    in_data  = W'(7);
    repeat (3) tick();
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_pop(p0, "stall_delivered");
    chk("stall_sum_const", last_sum, 4);
    chk("stall_sat_const", last_sat, 0);
    run_frame(0, 0, 0, 1, 0, 1, 0);

    // Gapped valid: only real accepts count.
    run_frame(2, 2, 2, 2, 1, 7, 1);

    // Asynchronous reset mid-frame.
    put(1, 0);
    put(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sum", int'(out_sum), 0);
    chk("arst_out_sat", int'(out_sat), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1, 1, 1, 1, 0, 4, 0);

    // Random frames with random gaps and random consumer back-pressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int s = 0; s < N; s++) begin
        put(int'($signed(W'($urandom))), int'($urandom_range(0, 2)));
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 64 && sb.size() > 0; n++) tick();
    repeat (2) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
